// File: rtl/credit_pkg.sv
// Shared types for the credit flow-control link: return FSM states and the
// width helper for occupancy/credit counters.
package credit_pkg;

    typedef enum logic [1:0] {
        IDLE,
        ACCUM,
        SEND
    } credit_state_t;

    // Bits needed to hold a count in 0..depth inclusive.
    function automatic int credit_w(input int depth);
        return $clog2(depth + 1);
    endfunction

endpackage

// File: rtl/credit_sink_if.sv
// Receive-side link bundle: enqueue from the transmitter, dequeue to the
// consumer, credit return back to the transmitter, and the overflow flag.
interface credit_sink_if #(
    parameter int DATA_W   = 32,
    parameter int count_sz = 10
);
    logic                enq__ENA;
    logic [DATA_W-1:0]   enq_v;
    logic                enq__RDY;
    logic                deq__ENA;
    logic [DATA_W-1:0]   deq;
    logic                deq__RDY;
    logic                creditReturn__ENA;
    logic [count_sz-1:0] creditReturn_v;
    logic                creditReturn__RDY;
    logic                overflow;

    // master: transmitter/consumer environment; slave: the sink itself
    modport master (
        output enq__ENA, enq_v, deq__ENA, creditReturn__RDY,
        input  enq__RDY, deq, deq__RDY, creditReturn__ENA, creditReturn_v, overflow
    );
    modport slave (
        input  enq__ENA, enq_v, deq__ENA, creditReturn__RDY,
        output enq__RDY, deq, deq__RDY, creditReturn__ENA, creditReturn_v, overflow
    );
endinterface

// File: rtl/credit_sink_fifo.sv
// Credit-protected receive FIFO: storage, pointers, occupancy and a sticky
// overflow detect for writes that arrive with no free slot.
module credit_sink_fifo
    import credit_pkg::*;
#(
    parameter int DEPTH  = 8,
    parameter int DATA_W = 32
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              enq_i,
    input  logic [DATA_W-1:0] enq_data_i,
    input  logic              deq_i,
    output logic [DATA_W-1:0] deq_data_o,
    output logic              deq_rdy_o,
    output logic              deq_acc_o,
    output logic              overflow_o
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = credit_w(DEPTH);

    logic [DATA_W-1:0] mem_q [DEPTH];
    logic [AW-1:0]     rd_ptr_q, wr_ptr_q;
    logic [CW-1:0]     cnt_q;
    logic              ovf_q;
    logic              empty, full, deq_acc, enq_acc;

    assign empty   = (cnt_q == '0);
    assign full    = (cnt_q == CW'(DEPTH));
    assign deq_acc = deq_i && !empty;
    // A pop in the same cycle frees the slot, so a write into a full FIFO still lands.
    assign enq_acc = enq_i && (!full || deq_acc);

    always_ff @(posedge clk_i) begin
        if (enq_acc) mem_q[wr_ptr_q] <= enq_data_i;
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            cnt_q    <= '0;
            ovf_q    <= 1'b0;
        end else begin
            if (enq_acc) wr_ptr_q <= wr_ptr_q + AW'(1);
            if (deq_acc) rd_ptr_q <= rd_ptr_q + AW'(1);
            case ({enq_acc, deq_acc})
                2'b10:   cnt_q <= cnt_q + CW'(1);
                2'b01:   cnt_q <= cnt_q - CW'(1);
                default: cnt_q <= cnt_q;
            endcase
            if (enq_i && !enq_acc) ovf_q <= 1'b1;
        end
    end

    assign deq_data_o = empty ? '0 : mem_q[rd_ptr_q];
    assign deq_rdy_o  = !empty;
    assign deq_acc_o  = deq_acc;
    assign overflow_o = ovf_q;

endmodule

// File: rtl/credit_sink.sv
// Credit sink top: FIFO plus the credit-return FSM. Define CREDIT_SINK_TIMEOUT_EN
// to batch returns to BATCH and flush residue after TIMEOUT idle cycles.
module credit_sink
    import credit_pkg::*;
#(
    parameter int DEPTH    = 8,
    parameter int DATA_W   = 32,
    parameter int count_sz = 10,
    parameter int BATCH    = 4,
    parameter int TIMEOUT  = 16
) (
    input  logic          CLK,
    input  logic          RST,
    credit_sink_if.slave  link
);
    localparam bit CFG_OK = (credit_w(DEPTH) <= count_sz) && (DEPTH >= 2) &&
                            (BATCH >= 1) && (BATCH <= DEPTH) && (TIMEOUT >= 1);

    credit_state_t       state_q, state_d;
    logic [count_sz-1:0] pending_q, pending_d, snap_q, snap_d;
    logic                deq_acc, xfer, flush;

    credit_sink_fifo #(.DEPTH(DEPTH), .DATA_W(DATA_W)) u_fifo (
        .clk_i      (CLK),
        .rst_i      (RST),
        .enq_i      (link.enq__ENA),
        .enq_data_i (link.enq_v),
        .deq_i      (link.deq__ENA),
        .deq_data_o (link.deq),
        .deq_rdy_o  (link.deq__RDY),
        .deq_acc_o  (deq_acc),
        .overflow_o (link.overflow)
    );

    assign xfer      = (state_q == SEND) && link.creditReturn__RDY;
    // Frees during an open offer accumulate here; snap stays frozen until the handshake.
    assign pending_d = pending_q + count_sz'(deq_acc) - (xfer ? snap_q : '0);

`ifdef CREDIT_SINK_TIMEOUT_EN
    localparam int TW = $clog2(TIMEOUT + 1);
    logic [TW-1:0] timer_q, timer_d;

    assign flush   = (pending_d >= count_sz'(BATCH)) ||
                     ((state_q == ACCUM) && (timer_q == TW'(TIMEOUT - 1)));
    assign timer_d = ((state_q == ACCUM) && (state_d == ACCUM)) ? timer_q + TW'(1) : '0;

    always_ff @(posedge CLK) begin
        if (RST) timer_q <= '0;
        else     timer_q <= timer_d;
    end
`else
    assign flush = (pending_d != '0);
`endif

    always_comb begin
        state_d = state_q;
        snap_d  = snap_q;
        unique case (state_q)
            IDLE: begin
                if (flush) begin
                    state_d = SEND;
                    snap_d  = pending_d;
                end else if (pending_d != '0) begin
                    state_d = ACCUM;
                end
            end
            ACCUM: begin
                if (flush) begin
                    state_d = SEND;
                    snap_d  = pending_d;
                end
            end
            SEND: begin
                if (xfer) state_d = (pending_d == '0) ? IDLE : ACCUM;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q   <= IDLE;
            pending_q <= '0;
            snap_q    <= '0;
        end else begin
            state_q   <= state_d;
            pending_q <= pending_d;
            snap_q    <= snap_d;
        end
    end

    assign link.enq__RDY          = 1'b1;
    assign link.creditReturn__ENA = (state_q == SEND);
    assign link.creditReturn_v    = (state_q == SEND) ? snap_q : '0;

    a_cfg_ok: assert property (@(posedge CLK) CFG_OK);

endmodule

// File: tb/tb_credit_sink.sv
// Randomized bench for credit_sink against a queue/counter model of the link,
// plus directed literal checks of the headline behaviours.
module tb_credit_sink;
    localparam int DEPTH = 8, DATA_W = 32, CSZ = 10, BATCH = 4, TIMEOUT = 16;

    logic CLK = 1'b0;
    logic RST = 1'b1;
    always #5 CLK = ~CLK;

    credit_sink_if #(.DATA_W(DATA_W), .count_sz(CSZ)) link();

    credit_sink #(.DEPTH(DEPTH), .DATA_W(DATA_W), .count_sz(CSZ),
                  .BATCH(BATCH), .TIMEOUT(TIMEOUT)) dut (
        .CLK  (CLK),
        .RST  (RST),
        .link (link)
    );

    // Model: buffered words, pending credits, the open offer, idle time in ACCUM.
    logic [DATA_W-1:0] q[$];
    int  pend = 0, offer_v = 0, idle = 0, tx_cnt = DEPTH;
    bit  offering = 0, accum = 0, ovf = 0, chk_en = 0;
    int  n_tests = 0, n_fail = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_step(input bit enq, input logic [DATA_W-1:0] d,
                              input bit deq, input bit rdy, input bit rst);
        int pn;
        bit deq_ok, was_full, xfer, flush;
        if (rst) begin
            q.delete();
            pend = 0; offering = 0; offer_v = 0; accum = 0; idle = 0; ovf = 0;
            return;
        end
        was_full = (q.size() == DEPTH);
        deq_ok   = deq && (q.size() > 0);
        if (deq_ok) void'(q.pop_front());
        if (enq && (!was_full || deq_ok)) q.push_back(d);
        else if (enq) ovf = 1;
        xfer = offering && rdy;
        pn   = pend + int'(deq_ok) - (xfer ? offer_v : 0);
`ifdef CREDIT_SINK_TIMEOUT_EN
        flush = (pn >= BATCH) || (accum && idle == TIMEOUT - 1);
`else
        flush = (pn != 0);
`endif
        if (offering) begin
            if (xfer) begin offering = 0; accum = (pn > 0); idle = 0; end
        end else if (flush) begin
            offering = 1; offer_v = pn; accum = 0;
        end else if (pn > 0) begin
            if (accum) idle++;
            else begin accum = 1; idle = 0; end
        end
        pend = pn;
    endtask

    task automatic step(input bit enq, input logic [DATA_W-1:0] d,
                        input bit deq, input bit rdy, input bit rst);
        RST = rst;
        link.enq__ENA = enq;
        link.enq_v = d;
        link.deq__ENA = deq;
        link.creditReturn__RDY = rdy;
        @(posedge CLK);
        if (rst) tx_cnt = DEPTH;
        else begin
            if (enq) tx_cnt--;
            if (offering && rdy) tx_cnt += offer_v;
        end
        model_step(enq, d, deq, rdy, rst);
        @(negedge CLK);
    endtask

    always @(negedge CLK) begin
        if (chk_en) begin
            chk("deq_rdy", link.deq__RDY, q.size() > 0);
            if (q.size() > 0) chk("deq", link.deq, q[0]);
            else              chk("deq", link.deq, 0);
            chk("enq_rdy", link.enq__RDY, 1);
            chk("cr_ena", link.creditReturn__ENA, offering);
            chk("cr_v", link.creditReturn_v, offering ? offer_v : 0);
            chk("overflow", link.overflow, ovf);
        end
    end

    initial begin
        bit e, dq, r, rs;
        link.enq__ENA = 0; link.enq_v = '0; link.deq__ENA = 0; link.creditReturn__RDY = 0;
        step(0, 0, 0, 0, 1);
        step(0, 0, 0, 0, 1);
        chk_en = 1;
        chk("lit_rst_deq_rdy", link.deq__RDY, 0);
        chk("lit_rst_deq", link.deq, 0);
        chk("lit_rst_cr_ena", link.creditReturn__ENA, 0);
        chk("lit_rst_cr_v", link.creditReturn_v, 0);
        chk("lit_rst_ovf", link.overflow, 0);

        for (int i = 0; i < DEPTH; i++) step(1, 32'hA0 + i, 0, 0, 0);
        chk("lit_fill_rdy", link.deq__RDY, 1);
        chk("lit_fill_head", link.deq, 32'hA0);
        chk("lit_fill_no_offer", link.creditReturn__ENA, 0);
        chk("lit_fill_ovf", link.overflow, 0);

`ifndef CREDIT_SINK_TIMEOUT_EN
        step(1, 32'hB0, 1, 0, 0);
        chk("lit_full_rw_ovf", link.overflow, 0);
        chk("lit_full_rw_head", link.deq, 32'hA1);
        chk("lit_first_offer", link.creditReturn__ENA, 1);
        chk("lit_first_v", link.creditReturn_v, 1);
        step(0, 0, 1, 0, 0);
        step(0, 0, 1, 0, 0);
        chk("lit_hold_v", link.creditReturn_v, 1);
        step(0, 0, 0, 1, 0);
        chk("lit_gap_ena", link.creditReturn__ENA, 0);
        step(0, 0, 0, 0, 0);
        chk("lit_second_v", link.creditReturn_v, 2);
        step(0, 0, 0, 1, 0);
        step(1, 32'hC0, 0, 0, 0);
        step(1, 32'hC1, 0, 0, 0);
        step(1, 32'hD0, 0, 0, 0);
        chk("lit_ovf_set", link.overflow, 1);
        step(0, 0, 0, 0, 0);
        chk("lit_ovf_sticky", link.overflow, 1);
        step(0, 0, 1, 0, 0);
        chk("lit_pre_rst_ena", link.creditReturn__ENA, 1);
`else
        for (int i = 0; i < 3; i++) step(0, 0, 1, 1, 0);
        chk("lit_batch_wait", link.creditReturn__ENA, 0);
        step(0, 0, 1, 1, 0);
        chk("lit_batch_ena", link.creditReturn__ENA, 1);
        chk("lit_batch_v", link.creditReturn_v, 4);
        step(0, 0, 0, 1, 0);
        chk("lit_batch_done", link.creditReturn__ENA, 0);
        step(0, 0, 1, 0, 0);
        for (int i = 0; i < TIMEOUT - 1; i++) step(0, 0, 0, 0, 0);
        chk("lit_tmo_wait", link.creditReturn__ENA, 0);
        step(0, 0, 0, 0, 0);
        chk("lit_tmo_ena", link.creditReturn__ENA, 1);
        chk("lit_tmo_v", link.creditReturn_v, 1);
        step(0, 0, 1, 0, 0);
        step(0, 0, 1, 0, 0);
        for (int i = 0; i < 3; i++) step(0, 0, 0, 0, 0);
        chk("lit_hold_v", link.creditReturn_v, 1);
        step(0, 0, 0, 1, 0);
        chk("lit_resid_ena", link.creditReturn__ENA, 0);
        for (int i = 0; i < DEPTH - 1; i++) step(1, 32'hC0 + i, 0, 0, 0);
        step(1, 32'hB0, 1, 0, 0);
        chk("lit_full_rw_ovf", link.overflow, 0);
        chk("lit_full_rw_rdy", link.deq__RDY, 1);
        step(1, 32'hD0, 0, 0, 0);
        chk("lit_ovf_set", link.overflow, 1);
        step(0, 0, 0, 0, 0);
        chk("lit_ovf_sticky", link.overflow, 1);
        step(0, 0, 1, 0, 0);
        chk("lit_pre_rst_v", link.creditReturn_v, 4);
`endif
        step(0, 0, 0, 0, 1);
        chk("lit_rst_offer_ena", link.creditReturn__ENA, 0);
        chk("lit_rst_offer_v", link.creditReturn_v, 0);
        chk("lit_rst_offer_rdy", link.deq__RDY, 0);
        chk("lit_rst_offer_ovf", link.overflow, 0);

        for (int blk = 0; blk < 6; blk++) begin
            int deq_pct, rdy_pct;
            deq_pct = 20 + 15 * blk;
            rdy_pct = (blk % 2 == 0) ? 80 : 30;
            for (int c = 0; c < 500; c++) begin
                rs = ($urandom_range(0, 399) == 0);
                e  = !rs && (tx_cnt > 0) && ($urandom_range(0, 99) < 60);
                dq = ($urandom_range(0, 99) < deq_pct);
                r  = ($urandom_range(0, 99) < rdy_pct);
                step(e, $urandom, dq, r, rs);
            end
        end

        chk_en = 0;
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
